// File: rtl/sdm_pkg.sv
// Shared types and arithmetic helpers for the multi-channel sigma-delta DAC modulator.
package sdm_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned GUARD_DEF  = 4;
    localparam int unsigned IW_DEF     = DATA_W_DEF + GUARD_DEF;
    localparam int unsigned CALC_W     = 64;

    typedef logic signed [CALC_W-1:0] calc_t;
    typedef logic signed [IW_DEF-1:0] integ_t;

    typedef enum logic {
        ORDER_1ST = 1'b0,
        ORDER_2ND = 1'b1
    } order_e;

    // Positive full-scale feedback: 2^(dw-1)-1
    function automatic calc_t fb_pos(input int unsigned dw);
        return (calc_t'(1) << (dw - 1)) - calc_t'(1);
    endfunction

    // Negative full-scale feedback: -2^(dw-1)
    function automatic calc_t fb_neg(input int unsigned dw);
        return -(calc_t'(1) << (dw - 1));
    endfunction

    // a + b clipped to the signed range of an iw-bit word
    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int unsigned iw);
        calc_t s;
        calc_t hi;
        calc_t lo;
        s  = a + b;
        hi = (calc_t'(1) << (iw - 1)) - calc_t'(1);
        lo = -(calc_t'(1) << (iw - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/sdm_dac_mc_chan.sv
// One modulator channel: integrators, primed flag and the 1-bit output.
module sdm_chan
    import sdm_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned GUARD  = GUARD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clear,
    input  logic              order,
    input  logic [DATA_W-1:0] x,
    output logic              b
);

    localparam int unsigned IW = DATA_W + GUARD;

    logic signed [IW-1:0] i1_q;
    logic signed [IW-1:0] i2_q;
    logic                 primed_q;
    calc_t                fb_c;
    calc_t                i1_c;
    calc_t                i2_c;

    // Candidate integrator values for this tick; feedback is zero until primed
    always_comb begin
        fb_c = '0;
        if (primed_q) fb_c = b ? fb_pos(DATA_W) : fb_neg(DATA_W);
        i1_c = sat_add(calc_t'(i1_q), calc_t'($signed(x)) - fb_c, IW);
        i2_c = sat_add(calc_t'(i2_q), i1_c - fb_c, IW);
    end

    // Output bit always follows the tick; a clear only wipes loop state
    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q     <= '0;
            i2_q     <= '0;
            primed_q <= 1'b0;
            b        <= 1'b0;
        end else begin
            if (tick) begin
                b <= (order == ORDER_2ND) ? (i2_c >= calc_t'(0)) : (i1_c >= calc_t'(0));
            end
            if (clear) begin
                i1_q     <= '0;
                i2_q     <= '0;
                primed_q <= 1'b0;
            end else if (tick) begin
                i1_q     <= IW'(i1_c);
                i2_q     <= (order == ORDER_2ND) ? IW'(i2_c) : '0;
                primed_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdm_dac_mc.sv
// Multi-channel sigma-delta DAC: frame handshake, pending/active buffers, OSR pacing.
module sdm_dac_mc
    import sdm_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned OSR      = 64,
    parameter int unsigned GUARD    = GUARD_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         order_sel,
    input  logic                         tick,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [CHANNELS*DATA_W-1:0]   audio_in,
    output logic                         valid_out,
    output logic [CHANNELS-1:0]          sdm_out,
    output logic                         underrun
);

    localparam int unsigned FW = CHANNELS * DATA_W;
    localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;

    logic [FW-1:0] pend_q;
    logic [FW-1:0] act_q;
    logic          full_q;
    logic          act_order_q;
    logic [CW-1:0] cnt_q;

    logic boundary_c;
    logic accept_c;
    logic clear_c;
    logic full_nxt_c;

    assign boundary_c = tick && (cnt_q == CW'(OSR - 1));
    assign accept_c   = valid_in && ready_in;
    assign clear_c    = boundary_c && full_q && (order_sel != act_order_q);

    // Accept and drain are mutually exclusive: accept needs an empty slot
    always_comb begin
        full_nxt_c = full_q;
        if (boundary_c && full_q) full_nxt_c = 1'b0;
        if (accept_c)             full_nxt_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            act_q       <= '0;
            full_q      <= 1'b0;
            act_order_q <= ORDER_1ST;
            cnt_q       <= '0;
            ready_in    <= 1'b1;
            valid_out   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            valid_out <= tick;
            full_q    <= full_nxt_c;
            ready_in  <= ~full_nxt_c;
            if (tick) cnt_q <= boundary_c ? '0 : cnt_q + CW'(1);
            if (boundary_c) begin
                if (full_q) begin
                    act_q       <= pend_q;
                    act_order_q <= order_sel;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (accept_c) pend_q <= audio_in;
        end
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
        sdm_chan #(
            .DATA_W (DATA_W),
            .GUARD  (GUARD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .clear (clear_c),
            .order (act_order_q),
            .x     (act_q[c*DATA_W +: DATA_W]),
            .b     (sdm_out[c])
        );
    end

endmodule

// File: tb/tb_sdm_dac_mc.sv
// Self-checking bench for sdm_dac_mc against a frame-level behavioural model.
module tb_sdm_dac_mc;

    localparam int CH  = 2;
    localparam int DW  = 16;
    localparam int OSR = 64;
    localparam int GD  = 4;
    localparam longint SAT_HI = (longint'(1) <<< (DW + GD - 1)) - 1;
    localparam longint SAT_LO = -(longint'(1) <<< (DW + GD - 1));
    localparam longint FPOS   = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint FNEG   = -(longint'(1) <<< (DW - 1));

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             order_sel = 1'b0;
    logic             tick = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in;
    logic [CH*DW-1:0] audio_in = '0;
    logic             valid_out;
    logic [CH-1:0]    sdm_out;
    logic             underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    longint m_pend [CH];
    longint m_act  [CH];
    longint m_i1   [CH];
    longint m_i2   [CH];
    bit     m_pr   [CH];
    bit     m_b    [CH];
    bit     m_full, m_ord, m_und, m_vo;
    int     m_cnt;

    sdm_dac_mc #(.CHANNELS(CH), .DATA_W(DW), .OSR(OSR), .GUARD(GD)) dut (
        .clk       (clk),
        .rst       (rst),
        .order_sel (order_sel),
        .tick      (tick),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .audio_in  (audio_in),
        .valid_out (valid_out),
        .sdm_out   (sdm_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    function automatic longint sat(input longint v);
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
        return v;
    endfunction

    function automatic logic [CH+2:0] exp_out();
        logic [CH+2:0] e;
        e[CH+2] = !m_full;
        e[CH+1] = m_vo;
        e[CH]   = m_und;
        for (int c = 0; c < CH; c++) e[c] = m_b[c];
        return e;
    endfunction

    function automatic logic [CH*DW-1:0] rand_frame();
        logic [CH*DW-1:0] f;
        for (int c = 0; c < CH; c++) f[c*DW +: DW] = DW'($urandom);
        return f;
    endfunction

    // Advance the model by one clock using the current inputs, then step the DUT
    task automatic cycle();
        bit     acc;
        bit     bnd;
        longint fb, n1, n2;
        acc = 0;
        bnd = 0;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_pend[c] = 0; m_act[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
                m_pr[c] = 0;   m_b[c] = 0;
            end
            m_full = 0; m_ord = 0; m_und = 0; m_vo = 0; m_cnt = 0;
        end else begin
            acc = valid_in && !m_full;
            if (tick) begin
                for (int c = 0; c < CH; c++) begin
                    fb = !m_pr[c] ? 0 : (m_b[c] ? FPOS : FNEG);
                    n1 = sat(m_i1[c] + m_act[c] - fb);
                    n2 = m_ord ? sat(m_i2[c] + n1 - fb) : 0;
                    m_b[c]  = m_ord ? (n2 >= 0) : (n1 >= 0);
                    m_i1[c] = n1;
                    m_i2[c] = n2;
                    m_pr[c] = 1;
                end
                bnd   = (m_cnt == OSR - 1);
                m_cnt = bnd ? 0 : m_cnt + 1;
            end
            if (bnd) begin
                if (m_full) begin
                    if (order_sel != m_ord)
                        for (int c = 0; c < CH; c++) begin
                            m_i1[c] = 0; m_i2[c] = 0; m_pr[c] = 0;
                        end
                    for (int c = 0; c < CH; c++) m_act[c] = m_pend[c];
                    m_ord  = order_sel;
                    m_full = 0;
                end else begin
                    m_und = 1;
                end
            end
            if (acc) begin
                for (int c = 0; c < CH; c++) m_pend[c] = longint'($signed(audio_in[c*DW +: DW]));
                m_full = 1;
            end
            m_vo = tick;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0; tick = 1'b0; order_sel = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; tick = 1'b1; audio_in = rand_frame();
        cycle();
        n_tests++;
        if ({ready_in, valid_out, underrun, sdm_out} !== {1'b1, 1'b0, 1'b0, {CH{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_values got=%b want=%b", {ready_in, valid_out, underrun, sdm_out},
                     {1'b1, 1'b0, 1'b0, {CH{1'b0}}});
        end
        rst = 1'b0; valid_in = 1'b0; tick = 1'b0;
    endtask

    task automatic test_zero_order1();
        logic [CH-1:0] want;
        do_reset();
        audio_in = '0; valid_in = 1'b1; tick = 1'b1; order_sel = 1'b0;
        for (int k = 0; k < OSR + 4; k++) begin
            cycle();
            valid_in = 1'b0;
            want = (k % 2 == 0) ? {CH{1'b1}} : {CH{1'b0}};
            n_tests++;
            if ({sdm_out, underrun} !== {want, 1'b0}) begin
                n_fail++;
                $display("FAIL zero_alternate k=%0d got=%b/%b want=%b/0", k, sdm_out, underrun, want);
            end
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL zero_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
    endtask

    task automatic test_extremes();
        logic [CH*DW-1:0] f;
        do_reset();
        f = '0;
        f[0*DW +: DW] = 16'sh7FFF;
        f[1*DW +: DW] = 16'sh8000;
        audio_in = f; valid_in = 1'b1; tick = 1'b1; order_sel = 1'b0;
        for (int k = 0; k < 2 * OSR; k++) begin
            cycle();
            valid_in = 1'b0;
            if (k >= OSR + 2) begin
                n_tests++;
                if (sdm_out[1:0] !== 2'b01) begin
                    n_fail++;
                    $display("FAIL extremes_const k=%0d got=%b want=01", k, sdm_out[1:0]);
                end
            end
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL extremes_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
    endtask

    task automatic test_order2_density();
        logic [CH*DW-1:0] f;
        int ones;
        do_reset();
        f = rand_frame();
        f[0*DW +: DW] = 16'sd16384;
        audio_in = f; valid_in = 1'b1; tick = 1'b1; order_sel = 1'b1;
        ones = 0;
        for (int k = 0; k < 5 * OSR; k++) begin
            cycle();
            if (k >= OSR && sdm_out[0] === 1'b1) ones++;
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL order2_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
        valid_in = 1'b0;
        n_tests++;
        if (ones < 3 * OSR - 2 || ones > 3 * OSR + 2) begin
            n_fail++;
            $display("FAIL order2_density got=%0d want=%0d+-2", ones, 3 * OSR);
        end
    endtask

    task automatic test_back_to_back();
        logic [CH*DW-1:0] fa, fb;
        int  stage;
        int  bounds;
        bit  acc;
        do_reset();
        fa = rand_frame(); fb = rand_frame();
        order_sel = 1'(($urandom) & 1);
        audio_in = fa; valid_in = 1'b1;
        stage = 0; bounds = 0;
        for (int k = 0; k < 20 * OSR && bounds < 3; k++) begin
            tick = 1'(($urandom_range(0, 3)) != 0);
            acc = valid_in && ready_in;
            if (tick && m_cnt == OSR - 1) bounds++;
            cycle();
            if (acc) begin
                stage++;
                if (stage == 1) audio_in = fb;
                else valid_in = 1'b0;
            end
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL b2b_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
        n_tests++;
        if (stage != 2 || bounds < 3) begin
            n_fail++;
            $display("FAIL b2b_progress got stage=%0d bounds=%0d want stage=2 bounds=3", stage, bounds);
        end
        valid_in = 1'b0; tick = 1'b0;
    endtask

    task automatic test_underrun();
        logic want;
        do_reset();
        audio_in = rand_frame(); valid_in = 1'b1; tick = 1'b1; order_sel = 1'b0;
        for (int k = 0; k < 3 * OSR; k++) begin
            cycle();
            valid_in = 1'b0;
            want = (k >= 2 * OSR - 1);
            n_tests++;
            if (underrun !== want) begin
                n_fail++;
                $display("FAIL underrun_flag k=%0d got=%b want=%b", k, underrun, want);
            end
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL underrun_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
    endtask

    task automatic test_order_flip();
        logic [CH*DW-1:0] f1, f2;
        logic [CH-1:0]    want;
        bit               acc;
        int               stage;
        do_reset();
        f1 = rand_frame(); f2 = rand_frame();
        audio_in = f1; valid_in = 1'b1; tick = 1'b1; order_sel = 1'b0;
        stage = 0;
        for (int k = 0; k < 2 * OSR + 8; k++) begin
            if (k == OSR + 5) order_sel = 1'b1;
            acc = valid_in && ready_in;
            cycle();
            if (acc) begin
                stage++;
                if (stage == 1) audio_in = f2;
                else valid_in = 1'b0;
            end
            if (k == 2 * OSR) begin
                for (int c = 0; c < CH; c++) want[c] = ($signed(f2[c*DW +: DW]) >= 0);
                n_tests++;
                if (sdm_out !== want) begin
                    n_fail++;
                    $display("FAIL flip_unprimed got=%b want=%b", sdm_out, want);
                end
            end
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL flip_model k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        audio_in = rand_frame(); valid_in = 1'b1; tick = 1'b1; order_sel = 1'b1;
        for (int k = 0; k < OSR + 10; k++) begin
            cycle();
            audio_in = rand_frame();
        end
        rst = 1'b1;
        cycle();
        n_tests++;
        if ({ready_in, valid_out, underrun, sdm_out} !== {1'b1, 1'b0, 1'b0, {CH{1'b0}}}) begin
            n_fail++;
            $display("FAIL rst_mid got=%b want=%b", {ready_in, valid_out, underrun, sdm_out},
                     {1'b1, 1'b0, 1'b0, {CH{1'b0}}});
        end
        rst = 1'b0; valid_in = 1'b0;
        for (int k = 0; k < OSR + 4; k++) begin
            tick = 1'(($urandom) & 1);
            cycle();
            n_tests++;
            if ({ready_in, valid_out, underrun, sdm_out} !== exp_out()) begin
                n_fail++;
                $display("FAIL rst_after k=%0d got=%b want=%b", k,
                         {ready_in, valid_out, underrun, sdm_out}, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_order1();
        test_extremes();
        test_order2_density();
        test_back_to_back();
        test_underrun();
        test_order_flip();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
